// File: rtl/srt_frame_ctrl_pkg.sv
// Shared state encoding and width helpers for the SRT frame sequencer.
package srt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int COEF_IDX_W = 4;

    // Width needed to hold 0..credits inclusive.
    function automatic int credit_cnt_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/srt_frame_ctrl_valid_pipe.sv
// Valid/last shift register that tracks datapath results in flight.
module srt_valid_pipe #(
    parameter int DEPTH = 40
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    // A last flag is only ever stored alongside a valid result.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else if (en) begin
            valid_sr[0] <= in_valid;
            last_sr[0]  <= in_valid & in_last;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/srt_frame_ctrl.sv
// Frame sequencer for the SRT matrix-vector + CORDIC datapath.
// Optional performance counters are enabled with SRT_FRAME_CTRL_PERF_EN.
module srt_frame_ctrl
    import srt_ctrl_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int MAT_BEATS = 3,
    parameter int PIPE_LAT  = 40,
    parameter int CREDITS   = 64
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    input  logic                  fifo_pop,
    output logic                  coef_we,
    output logic [COEF_IDX_W-1:0] coef_base,
    output logic                  load_matrix,
    output logic                  vec_valid,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_short
`ifdef SRT_FRAME_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_frames,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_results
`endif
);

    localparam int CNT_W = credit_cnt_w(CREDITS);
    localparam logic [COEF_IDX_W-1:0] LAST_BEAT  = COEF_IDX_W'(MAT_BEATS - 1);
    localparam logic [CNT_W-1:0]      CREDIT_MAX = CNT_W'(CREDITS);

    state_t                  state;
    state_t                  state_nxt;
    logic [COEF_IDX_W-1:0]   beat_cnt;
    logic [COEF_IDX_W-1:0]   beat_cnt_nxt;
    logic                    load_pend;
    logic                    load_pend_nxt;
    logic [CNT_W-1:0]        credit_used;
    logic                    pop_eff;

    logic                    ready_c;
    logic                    coef_we_c;
    logic                    vec_c;
    logic                    err_c;
    logic                    done_c;
    logic                    pipe_en;
    logic                    pipe_valid;
    logic                    pipe_last;
    logic [COEF_IDX_W-1:0]   base_c;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            load_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            load_pend <= load_pend_nxt;
        end
    end

    // A tlast while coefficients are still loading aborts the frame; the beat
    // is still written so the coefficient bank sees a consistent write stream.
    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        load_pend_nxt = 1'b0;
        ready_c       = 1'b0;
        coef_we_c     = 1'b0;
        vec_c         = 1'b0;
        err_c         = 1'b0;
        done_c        = 1'b0;
        pipe_en       = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (s_tvalid) begin
                    coef_we_c = 1'b1;
                    if (s_tlast) begin
                        err_c = 1'b1;
                    end else if (MAT_BEATS == 1) begin
                        state_nxt     = STREAM;
                        load_pend_nxt = 1'b1;
                    end else begin
                        state_nxt    = LOAD;
                        beat_cnt_nxt = COEF_IDX_W'(1);
                    end
                end
            end
            LOAD: begin
                ready_c = 1'b1;
                if (s_tvalid) begin
                    coef_we_c = 1'b1;
                    if (s_tlast) begin
                        err_c        = 1'b1;
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end else if (beat_cnt == LAST_BEAT) begin
                        state_nxt     = STREAM;
                        load_pend_nxt = 1'b1;
                        beat_cnt_nxt  = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + COEF_IDX_W'(1);
                    end
                end
            end
            STREAM: begin
                ready_c = (credit_used < CREDIT_MAX);
                pipe_en = 1'b1;
                if (s_tvalid && ready_c) begin
                    vec_c = 1'b1;
                    if (s_tlast) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                pipe_en = 1'b1;
                if (pipe_last) begin
                    done_c       = 1'b1;
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    // Credits cover both in-flight and queued results; an empty-counter pop is ignored.
    assign pop_eff = fifo_pop && (credit_used != '0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            credit_used <= '0;
        end else if (vec_c && !pop_eff) begin
            credit_used <= credit_used + CNT_W'(1);
        end else if (!vec_c && pop_eff) begin
            credit_used <= credit_used - CNT_W'(1);
        end
    end

    srt_valid_pipe #(
        .DEPTH(PIPE_LAT)
    ) u_pipe (
        .clk      (aclk),
        .clear    (areset),
        .en       (pipe_en),
        .in_valid (vec_c),
        .in_last  (s_tlast),
        .out_valid(pipe_valid),
        .out_last (pipe_last)
    );

    assign base_c = COEF_IDX_W'(int'(beat_cnt) * LANES);

    // Every output is held low while reset is asserted.
    assign s_tready    = ready_c & ~areset;
    assign coef_we     = coef_we_c & ~areset;
    assign coef_base   = areset ? '0 : base_c;
    assign load_matrix = load_pend & ~areset;
    assign vec_valid   = vec_c & ~areset;
    assign out_valid   = pipe_valid & ~areset;
    assign out_last    = pipe_last & ~areset;
    assign busy        = (state != IDLE) & ~areset;
    assign frame_done  = done_c & ~areset;
    assign err_short   = err_c & ~areset;

`ifdef SRT_FRAME_CTRL_PERF_EN
    logic [31:0] frames_q;
    logic [31:0] stall_q;
    logic [31:0] results_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            frames_q  <= '0;
            stall_q   <= '0;
            results_q <= '0;
        end else begin
            frames_q  <= frames_q + {31'd0, done_c};
            stall_q   <= stall_q + {31'd0, (state == STREAM) && s_tvalid && !ready_c};
            results_q <= results_q + {31'd0, pipe_valid};
        end
    end

    assign perf_frames  = areset ? '0 : frames_q;
    assign perf_stall   = areset ? '0 : stall_q;
    assign perf_results = areset ? '0 : results_q;
`endif

endmodule
